regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_mp_pkg.sv | 13 +
 rtl/regfile_rdport.sv | 50 +++++
 rtl/regfile_mp.sv | 105 ++++++++++
 tb/tb_regfile_mp.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/regfile_mp_pkg.sv
// Shared types and default geometry for the multi-port register file.
package regfile_mp_pkg;

    localparam int unsigned DwDefault  = 72;
    localparam int unsigned AwDefault  = 6;
    localparam int unsigned NrdDefault = 2;

    typedef enum logic {
        StClear,
        StRun
    } state_e;

endpackage

// File: rtl/regfile_rdport.sv
// One registered read port with write-through bypass and optional hard-wired zero entry.
module regfile_rdport
    import regfile_mp_pkg::*;
#(
    parameter int unsigned DW      = DwDefault,
    parameter int unsigned AW      = AwDefault,
    parameter int unsigned ZERO_R0 = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [AW-1:0] raddr,
    input  logic [DW-1:0] mem_data,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          rvalid
);

    logic [DW-1:0] rdata_q, rdata_d;
    logic          rvalid_q;

    always_comb begin
        rdata_d = rdata_q;
        if (en) begin
            if ((ZERO_R0 != 0) && (raddr == '0)) begin
                rdata_d = '0;
            end else if (we && (waddr == raddr)) begin
                rdata_d = wdata;
            end else begin
                rdata_d = mem_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rdata_q  <= rdata_d;
            rvalid_q <= en;
        end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with a zeroing sweep after reset or on clr.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int unsigned DW      = DwDefault,
    parameter int unsigned AW      = AwDefault,
    parameter int unsigned NRD     = NrdDefault,
    parameter int unsigned ZERO_R0 = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    output logic              ready,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DW-1:0]     wdata,
    input  logic [NRD-1:0]    re,
    input  logic [NRD*AW-1:0] raddr,
    output logic [NRD*DW-1:0] rdata,
    output logic [NRD-1:0]    rvalid
);

    localparam int unsigned DEPTH = 2 ** AW;

    state_e        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          run;
    logic          wr_req;
    logic          wr_en;

    logic [DW-1:0] mem [DEPTH];

    assign run    = (state_q == StRun);
    assign ready  = run;
    assign wr_req = run && we;
    // Address 0 writes are dropped when it is hard-wired to zero.
    assign wr_en  = wr_req && !((ZERO_R0 != 0) && (waddr == '0));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StClear: begin
                if (clr) begin
                    cnt_d = '0;
                end else if (cnt_q == {AW{1'b1}}) begin
                    state_d = StRun;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StRun: begin
                if (clr) begin
                    state_d = StClear;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = StClear;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StClear;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The array itself is never reset; the sweep defines its contents.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (!run) begin
                mem[cnt_q] <= '0;
            end else if (wr_en) begin
                mem[waddr] <= wdata;
            end
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        regfile_rdport #(
            .DW      (DW),
            .AW      (AW),
            .ZERO_R0 (ZERO_R0)
        ) u_rdport (
            .clk      (clk),
            .rst_n    (rst_n),
            .en       (run && re[k]),
            .raddr    (raddr[k*AW +: AW]),
            .mem_data (mem[raddr[k*AW +: AW]]),
            .we       (wr_req),
            .waddr    (waddr),
            .wdata    (wdata),
            .rdata    (rdata[k*DW +: DW]),
            .rvalid   (rvalid[k])
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: a plain instance and one with entry 0 hard-wired to zero.
module tb_regfile_mp;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         clr;
    logic         we;
    logic [5:0]   waddr;
    logic [71:0]  wdata;
    logic [1:0]   re;
    logic [11:0]  raddr;
    logic         ready, ready_z;
    logic [143:0] rdata, rdata_z;
    logic [1:0]   rvalid, rvalid_z;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    regfile_mp #(.DW(72), .AW(6), .NRD(2), .ZERO_R0(0)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .ready(ready), .we(we), .waddr(waddr),
        .wdata(wdata), .re(re), .raddr(raddr), .rdata(rdata), .rvalid(rvalid)
    );

    regfile_mp #(.DW(72), .AW(6), .NRD(2), .ZERO_R0(1)) dut_z (
        .clk(clk), .rst_n(rst_n), .clr(clr), .ready(ready_z), .we(we), .waddr(waddr),
        .wdata(wdata), .re(re), .raddr(raddr), .rdata(rdata_z), .rvalid(rvalid_z)
    );

    typedef struct {
        logic        we;
        logic [5:0]  waddr;
        logic [71:0] wdata;
        logic [1:0]  re;
        logic [5:0]  ra0;
        logic [5:0]  ra1;
        logic [1:0]  rv;
        logic [71:0] rd0;
        logic [71:0] rd1;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic [5:0] wa, input logic [71:0] wd,
                         input logic [1:0] r, input logic [5:0] ra0, input logic [5:0] ra1);
        we    = w;
        waddr = wa;
        wdata = wd;
        re    = r;
        raddr = {ra1, ra0};
    endtask

    task automatic read_all_zero(input string name);
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 6'd0, 72'd0, 2'b11, 6'(i), 6'(i + 32));
            step();
            chk(name, {14'd0, rvalid, rdata}, {14'd0, 2'b11, 144'd0});
            chk({name, "_z"}, {14'd0, rvalid_z, rdata_z}, {14'd0, 2'b11, 144'd0});
        end
        drive(1'b0, 6'd0, 72'd0, 2'b00, 6'd0, 6'd0);
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!ready && n < 100) begin
            step();
            n++;
        end
        chk(name, 160'(n), 160'd64);
        chk({name, "_z"}, 160'(ready_z), 160'd1);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 6'd5,  72'hAB_CDEF_0123_4567_89AB, 2'b00, 6'd0, 6'd0, 2'b00,
                     72'h0, 72'h0};
        vecs[1]  = '{1'b0, 6'd0,  72'h0, 2'b01, 6'd5, 6'd0, 2'b01,
                     72'hAB_CDEF_0123_4567_89AB, 72'h0};
        vecs[2]  = '{1'b1, 6'd9,  72'h1234, 2'b11, 6'd9, 6'd9, 2'b11, 72'h1234, 72'h1234};
        vecs[3]  = '{1'b0, 6'd0,  72'h0, 2'b00, 6'd0, 6'd0, 2'b00, 72'h1234, 72'h1234};
        vecs[4]  = '{1'b1, 6'd5,  72'h55, 2'b10, 6'd0, 6'd5, 2'b10, 72'h1234, 72'h55};
        vecs[5]  = '{1'b0, 6'd0,  72'h0, 2'b11, 6'd9, 6'd5, 2'b11, 72'h1234, 72'h55};
        vecs[6]  = '{1'b1, 6'd0,  72'h77, 2'b01, 6'd0, 6'd0, 2'b01, 72'h77, 72'h55};
        vecs[7]  = '{1'b0, 6'd0,  72'h0, 2'b11, 6'd0, 6'd63, 2'b11, 72'h77, 72'h0};
        vecs[8]  = '{1'b1, 6'd63, 72'hDEAD, 2'b00, 6'd0, 6'd0, 2'b00, 72'h77, 72'h0};
        vecs[9]  = '{1'b0, 6'd0,  72'h0, 2'b11, 6'd63, 6'd63, 2'b11, 72'hDEAD, 72'hDEAD};
        vecs[10] = '{1'b0, 6'd0,  72'h0, 2'b11, 6'd5, 6'd9, 2'b11, 72'h55, 72'h1234};

        rst_n = 1'b0;
        clr   = 1'b0;
        drive(1'b0, 6'd0, 72'd0, 2'b00, 6'd0, 6'd0);
        step();
        step();
        chk("rst_ready", 160'({ready, ready_z}), 160'd0);
        chk("rst_rvalid", 160'({rvalid, rvalid_z}), 160'd0);
        chk("rst_rdata", 160'(rdata | rdata_z), 160'd0);

        // Post-reset sweep with reads and a write hammering the ports.
        rst_n = 1'b1;
        drive(1'b1, 6'd3, 72'hFF, 2'b11, 6'd3, 6'd4);
        for (int i = 1; i <= 64; i++) begin
            step();
            chk("sweep_ready", 160'(ready), 160'(i == 64));
            chk("sweep_rvalid", 160'({rvalid, rvalid_z}), 160'd0);
            chk("sweep_rdata", 160'(rdata), 160'd0);
        end
        drive(1'b0, 6'd0, 72'd0, 2'b00, 6'd0, 6'd0);
        read_all_zero("init_zero");

        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].we, vecs[i].waddr, vecs[i].wdata, vecs[i].re, vecs[i].ra0, vecs[i].ra1);
            step();
            chk($sformatf("vec%0d_rvalid", i), 160'(rvalid), 160'(vecs[i].rv));
            chk($sformatf("vec%0d_rvalid_z", i), 160'(rvalid_z), 160'(vecs[i].rv));
            chk($sformatf("vec%0d_rdata", i), 160'(rdata), 160'({vecs[i].rd1, vecs[i].rd0}));
        end

        // Entry 0 hard-wired to zero: plain write, read, and bypass read.
        drive(1'b1, 6'd0, 72'hFF, 2'b00, 6'd0, 6'd0);
        step();
        drive(1'b0, 6'd0, 72'd0, 2'b01, 6'd0, 6'd0);
        step();
        chk("r0_plain", 160'(rdata[71:0]), 160'h0FF);
        chk("r0_zero", {87'd0, rvalid_z[0], rdata_z[71:0]}, {87'd0, 1'b1, 72'h0});
        drive(1'b1, 6'd0, 72'hAA, 2'b10, 6'd0, 6'd0);
        step();
        chk("r0_byp_plain", 160'(rdata[143:72]), 160'h0AA);
        chk("r0_byp_zero", {87'd0, rvalid_z[1], rdata_z[143:72]}, {87'd0, 1'b1, 72'h0});
        drive(1'b0, 6'd0, 72'd0, 2'b00, 6'd0, 6'd0);

        // clr in RUN, then clr again mid-sweep restarts the count.
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_ready", 160'({ready, ready_z}), 160'd0);
        for (int i = 0; i < 20; i++) step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        wait_ready("clr_restart_len");

        for (int i = 0; i < 64; i++) begin
            drive(1'b1, 6'(i), {8'(i + 1), 64'hA5A5_5A5A_0F0F_F0F0}, 2'b00, 6'd0, 6'd0);
            step();
        end
        drive(1'b0, 6'd0, 72'd0, 2'b01, 6'd10, 6'd0);
        step();
        chk("fill_rd10", 160'(rdata[71:0]), 160'({8'd11, 64'hA5A5_5A5A_0F0F_F0F0}));

        // Reset lands at sweep count 30.
        drive(1'b0, 6'd0, 72'd0, 2'b00, 6'd0, 6'd0);
        clr = 1'b1;
        step();
        clr = 1'b0;
        for (int i = 0; i < 30; i++) step();
        rst_n = 1'b0;
        step();
        chk("midrst_ready", 160'({ready, ready_z}), 160'd0);
        chk("midrst_rvalid", 160'({rvalid, rvalid_z}), 160'd0);
        chk("midrst_rdata", 160'(rdata), 160'd0);
        rst_n = 1'b1;
        wait_ready("midrst_sweep_len");
        read_all_zero("midrst_zero");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
